// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite slave-side bus bundle for ahbl_sram_slave.
// The master modport drives the request and the bus-wide HREADY; the slave modport drives the response.
interface ahbl_sram_slave_if #(
    parameter int AW = 12
);
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [31:0]   hwdata;
    logic          hreadyin;
    logic          hreadyout;
    logic          hresp;
    logic [31:0]   hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hreadyin,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hreadyin,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite slave in front of a single-port synchronous SRAM with one cycle of read latency.
// Define AHBL_SRAM_ERROR_RESP_EN to answer bad size/alignment with a two-cycle ERROR response.
module ahbl_sram_slave #(
    parameter int AW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    ahbl_sram_slave_if.slave bus,
    output logic             ram_en,
    output logic [3:0]       ram_we,
    output logic [AW-3:0]    ram_addr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata
);
    typedef enum logic [2:0] {
        IDLE, RD_DATA, WR_DATA, RD_PEND, RD_WAIT
`ifdef AHBL_SRAM_ERROR_RESP_EN
        , ERR1, ERR2
`endif
    } state_t;

    state_t        state;
    logic [AW-1:0] lat_addr;
    logic [2:0]    lat_size;
    logic          stall;
    logic          bad;
    logic          accept;
    logic          rd_now;

    // Without the error option, unaligned low bits are simply ignored by the mask.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    lane_mask = 4'b0001 << a;
            3'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    always_comb begin
        stall = (state == RD_PEND);
`ifdef AHBL_SRAM_ERROR_RESP_EN
        stall = stall | (state == ERR1);
`endif
    end

    always_comb begin
        bad = 1'b0;
`ifdef AHBL_SRAM_ERROR_RESP_EN
        bad = (bus.hsize > 3'd2)
            || (bus.hsize == 3'd1 && bus.haddr[0])
            || (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00);
`endif
    end

    // rst_n gating keeps the combinational read strobe quiet while reset is held.
    assign accept = rst_n & bus.hsel & bus.htrans[1] & bus.hreadyin & ~stall;
    assign rd_now = accept & ~bus.hwrite & ~bad & (state != WR_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_addr <= '0;
            lat_size <= '0;
        end else begin
            case (state)
                RD_PEND: state <= RD_WAIT;
`ifdef AHBL_SRAM_ERROR_RESP_EN
                ERR1:    state <= ERR2;
`endif
                default: begin
                    if (!accept) begin
                        state <= IDLE;
`ifdef AHBL_SRAM_ERROR_RESP_EN
                    end else if (bad) begin
                        state <= ERR1;
`endif
                    end else if (bus.hwrite) begin
                        state    <= WR_DATA;
                        lat_addr <= bus.haddr;
                        lat_size <= bus.hsize;
                    end else if (state == WR_DATA) begin
                        // SRAM port is taken by the write data phase: replay the read next cycle.
                        state    <= RD_PEND;
                        lat_addr <= bus.haddr;
                        lat_size <= bus.hsize;
                    end else begin
                        state <= RD_DATA;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.hreadyout = ~stall;
        bus.hresp     = 1'b0;
        bus.hrdata    = '0;
        ram_en        = 1'b0;
        ram_we        = 4'b0000;
        ram_addr      = bus.haddr[AW-1:2];
        ram_wdata     = bus.hwdata;
        case (state)
            RD_DATA, RD_WAIT: bus.hrdata = ram_rdata;
            WR_DATA: begin
                ram_en   = 1'b1;
                ram_we   = lane_mask(lat_size, lat_addr[1:0]);
                ram_addr = lat_addr[AW-1:2];
            end
            RD_PEND: begin
                ram_en   = 1'b1;
                ram_addr = lat_addr[AW-1:2];
            end
`ifdef AHBL_SRAM_ERROR_RESP_EN
            ERR1, ERR2: bus.hresp = 1'b1;
`endif
            default: ;
        endcase
        if (rd_now) ram_en = 1'b1;
    end
endmodule

// File: doc/ahbl_sram_slave.md
AHBL_SRAM_SLAVE -- requirements
Module: ahbl_sram_slave

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter AW, default 12, byte-address width of the RAM window (4 KB).
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  sole clock
- rst_n  in  1  async active-low reset
- hsel  in  1  slave select
- haddr  in  AW  byte address
- htrans  in  2  transfer type; bit1 = NONSEQ/SEQ
- hwrite  in  1  1 = write
- hsize  in  3  0 byte, 1 half, 2 word
- hwdata  in  32  write data (data phase)
- hreadyin  in  1  bus-wide HREADY
- hreadyout  out  1  slave ready
- hresp  out  1  1 = ERROR
- hrdata  out  32  read data
- ram_en  out  1  SRAM access strobe
- ram_we  out  4  SRAM byte write enables
- ram_addr  out  AW-2  SRAM word address
- ram_wdata  out  32  SRAM write data
- ram_rdata  in  32  SRAM read data, valid one cycle after ram_en with ram_we==0

Function
REQ-004 SHALL accept an address phase only when hsel & htrans[1] & hreadyin.
- IDLE/BUSY or unselected: OKAY, zero wait, no SRAM access.
REQ-005 SHALL use FSM states IDLE, RD_DATA, WR_DATA, RD_PEND, RD_WAIT, ERR1, ERR2.
REQ-006 Read, port free: ram_en=1 and ram_addr=haddr[AW-1:2] combinationally in the address cycle.
- Next state RD_DATA: hreadyout=1, hrdata=ram_rdata (zero wait).
REQ-007 Write: address and hsize registered; next state WR_DATA.
- WR_DATA drives ram_en=1, ram_wdata=hwdata, ram_we=lane mask, hreadyout=1.
REQ-008 Lane mask from hsize and haddr[1:0]:
- byte: 4'b0001 << a[1:0]
- half: 4'b0011 << {a[1],0}
- word: 4'b1111
REQ-009 Read address phase accepted during WR_DATA (port busy):
- read address is latched and the state goes to RD_PEND.
- RD_PEND: ram_en=1 on the latched address, ram_we=0, hreadyout=0.
- RD_WAIT: hreadyout=1, hrdata=ram_rdata.
- Net cost: exactly one wait state.
REQ-010 A write address phase accepted during WR_DATA SHALL chain back to WR_DATA with no wait.
REQ-011 hrdata SHALL be 0 outside RD_DATA/RD_WAIT.
- hresp SHALL be 0 except in ERR1/ERR2.
REQ-012 Back-to-back reads SHALL sustain one transfer per cycle.
REQ-013 SHALL NOT issue any SRAM access for an ERROR transfer.

Reset
REQ-014 Reset (async assert, sync release) SHALL produce:
- state IDLE, hreadyout=1, hresp=0, hrdata=0, ram_en=0, ram_we=0.
- latched address/size cleared.
REQ-015 Reset during RD_PEND or WR_DATA SHALL abort the transfer; no SRAM write after reset assertion.

Configuration
REQ-016 Macro AHBL_SRAM_ERROR_RESP_EN.
- Defined: an accepted transfer with hsize>2, half at odd address, or word with haddr[1:0]!=0 SHALL take a two-cycle ERROR response.
  - ERR1: hresp=1, hreadyout=0.
  - ERR2: hresp=1, hreadyout=1.
  - then IDLE, or a newly accepted transfer.
- Undefined: hresp tied 0; haddr low bits aligned down per hsize; hsize>2 treated as word; ERR states absent.

Verification
REQ-017 The bench SHALL cover:
- Word write 0xDEADBEEF @0x010 then read @0x010 in the next address cycle: write OKAY; one wait state; hrdata=0xDEADBEEF.
- Byte write 0xAA @0x013: ram_we=4'b1000, ram_addr=0x004; subsequent word read returns 0xAAxxxxxx with other bytes unchanged.
- Four back-to-back reads @0x000, 0x004, 0x008, 0x00C: hreadyout=1 every cycle; data returned in order.
- Write then write @0x020, 0x024: zero wait; both ram_we=4'b1111 in consecutive cycles.
- With AHBL_SRAM_ERROR_RESP_EN, word read @0x002: ram_en=0; cycle 1 hresp=1/hreadyout=0, cycle 2 hresp=1/hreadyout=1. Without the macro: OKAY, data of 0x000.
- rst_n low in RD_PEND: hreadyout=1, ram_en=0 immediately; no stale hrdata after release.
